// File: rtl/wb_decoder_multi.sv
// Wishbone address decoder: routes one master transaction at a time to NUM_SLV
// slaves by base/mask window, with miss/timeout error responses and abort handling.
module wb_decoder_multi #(
  parameter int                    NUM_SLV  = 2,
  parameter int                    DW       = 32,
  parameter int                    AW       = 32,
  parameter logic [NUM_SLV*AW-1:0] SLV_BASE = {32'h3800_0000, 32'h3000_0000},
  parameter logic [NUM_SLV*AW-1:0] SLV_MASK = {32'hFF00_0000, 32'hFF00_0000},
  parameter int                    TIMEOUT  = 255,
  parameter logic [DW-1:0]         ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic                  wbs_clk_i,
  input  logic                  wbs_rst_ni,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_we_i,
  input  logic [DW/8-1:0]       wbs_sel_i,
  input  logic [AW-1:0]         wbs_adr_i,
  input  logic [DW-1:0]         wbs_dat_i,
  output logic                  wbs_ack_o,
  output logic [DW-1:0]         wbs_dat_o,
  output logic [NUM_SLV-1:0]    s_cyc_o,
  output logic [NUM_SLV-1:0]    s_stb_o,
  output logic                  s_we_o,
  output logic [DW/8-1:0]       s_sel_o,
  output logic [AW-1:0]         s_adr_o,
  output logic [DW-1:0]         s_dat_o,
  input  logic [NUM_SLV-1:0]    s_ack_i,
  input  logic [NUM_SLV*DW-1:0] s_dat_i,
  output logic [7:0]            err_cnt_o
);

  localparam int IW = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    MISS = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t          state_reg, state_next;
  logic [IW-1:0]   idx_reg, idx_next;
  logic [TW-1:0]   timer_reg, timer_next;
  logic            we_reg, we_next;
  logic [DW/8-1:0] sel_reg, sel_next;
  logic [AW-1:0]   adr_reg, adr_next;
  logic [DW-1:0]   wdat_reg, wdat_next;
  logic [DW-1:0]   rdat_reg, rdat_next;
  logic [7:0]      err_reg, err_next;

  logic [NUM_SLV-1:0] hit;
  logic [DW-1:0]      slv_rdata [NUM_SLV];
  logic [IW-1:0]      hit_idx;
  logic               any_hit;
  logic               sel_ack;
  logic               in_fwd;

  assign in_fwd = (state_reg == FWD);

  // Per-slave window compare, read-data unpacking and strobe fan-out.
  for (genvar gi = 0; gi < NUM_SLV; gi++) begin : g_slv
    localparam logic [AW-1:0] BASE = SLV_BASE[gi*AW +: AW];
    localparam logic [AW-1:0] MASK = SLV_MASK[gi*AW +: AW];

    assign hit[gi]       = ((wbs_adr_i & MASK) == (BASE & MASK));
    assign slv_rdata[gi] = s_dat_i[gi*DW +: DW];
    assign s_cyc_o[gi]   = in_fwd && (idx_reg == IW'(gi));
    assign s_stb_o[gi]   = in_fwd && (idx_reg == IW'(gi));
  end

  // Lowest index wins when windows overlap.
  always_comb begin
    hit_idx = '0;
    for (int i = NUM_SLV - 1; i >= 0; i--) begin
      if (hit[i]) hit_idx = IW'(i);
    end
  end

  assign any_hit = |hit;
  assign sel_ack = s_ack_i[idx_reg];

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    timer_next = timer_reg;
    we_next    = we_reg;
    sel_next   = sel_reg;
    adr_next   = adr_reg;
    wdat_next  = wdat_reg;
    rdat_next  = rdat_reg;
    err_next   = err_reg;

    unique case (state_reg)
      IDLE: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          we_next   = wbs_we_i;
          sel_next  = wbs_sel_i;
          adr_next  = wbs_adr_i;
          wdat_next = wbs_dat_i;
          if (any_hit) begin
            idx_next   = hit_idx;
            timer_next = '0;
            state_next = FWD;
          end else begin
            state_next = MISS;
          end
        end
      end

      FWD: begin
        // Abort beats ack; ack beats a simultaneous timeout.
        if (!wbs_cyc_i) begin
          state_next = IDLE;
        end else if (sel_ack) begin
          rdat_next  = slv_rdata[idx_reg];
          state_next = RESP;
        end else if (timer_reg == TIMER_LAST) begin
          rdat_next  = ERR_DATA;
          err_next   = (err_reg == 8'hFF) ? err_reg : err_reg + 8'd1;
          state_next = RESP;
        end else begin
          timer_next = timer_reg + TW'(1);
        end
      end

      MISS: begin
        rdat_next  = ERR_DATA;
        err_next   = (err_reg == 8'hFF) ? err_reg : err_reg + 8'd1;
        state_next = RESP;
      end

      RESP: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge wbs_clk_i or negedge wbs_rst_ni) begin
    if (!wbs_rst_ni) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      timer_reg <= '0;
      we_reg    <= 1'b0;
      sel_reg   <= '0;
      adr_reg   <= '0;
      wdat_reg  <= '0;
      rdat_reg  <= '0;
      err_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      timer_reg <= timer_next;
      we_reg    <= we_next;
      sel_reg   <= sel_next;
      adr_reg   <= adr_next;
      wdat_reg  <= wdat_next;
      rdat_reg  <= rdat_next;
      err_reg   <= err_next;
    end
  end

  assign wbs_ack_o = (state_reg == RESP);
  assign wbs_dat_o = rdat_reg;
  assign s_we_o    = we_reg;
  assign s_sel_o   = sel_reg;
  assign s_adr_o   = adr_reg;
  assign s_dat_o   = wdat_reg;
  assign err_cnt_o = err_reg;

endmodule

// File: doc/wb_decoder_multi.md
Name: wb_decoder_multi

Overview:
- Parametrised successor to the user-area Wishbone decoder; sits directly under user_project_wrapper, between the management-SoC Wishbone slave port and NUM_SLV user peripherals (e.g. FIR engine, exmem).
- Decodes each transaction by base/mask window and forwards it to one slave through registered request and response stages.
- Adds a per-transaction timeout, an error response for unmapped addresses, master-abort handling and a saturating error counter.

Parameters:
- NUM_SLV, 2, number of downstream slave ports (1..8).
- DW, 32, data width.
- AW, 32, address width.
- SLV_BASE, {32'h3800_0000, 32'h3000_0000}, packed NUM_SLV*AW base addresses; slave i uses bits [i*AW +: AW].
- SLV_MASK, {32'hFF00_0000, 32'hFF00_0000}, packed compare masks. Hit when (adr & mask) == (base & mask).
- TIMEOUT, 255, maximum FWD cycles waiting for a slave ack; must be at least 1.
- ERR_DATA, 32'hDEAD_BEEF, read data returned on miss or timeout.

Ports:
- wbs_clk_i  in  1  system clock.
- wbs_rst_ni  in  1  asynchronous active-low reset.
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  master cycle, strobe and write enable.
- wbs_sel_i  in  DW/8  byte selects.
- wbs_adr_i  in  AW  address.
- wbs_dat_i  in  DW  write data.
- wbs_ack_o  out  1  registered one-cycle ack.
- wbs_dat_o  out  DW  registered read data.
- s_cyc_o, s_stb_o  out  NUM_SLV  per-slave cycle and strobe, one-hot or zero.
- s_we_o  out  1  shared write enable.
- s_sel_o  out  DW/8  shared byte selects.
- s_adr_o  out  AW  shared address.
- s_dat_o  out  DW  shared write data.
- s_ack_i  in  NUM_SLV  per-slave ack.
- s_dat_i  in  NUM_SLV*DW  packed per-slave read data.
- err_cnt_o  out  8  saturating count of misses plus timeouts.

Behaviour:
- Reset:
  - wbs_rst_ni low asynchronously forces state IDLE.
  - All outputs go to 0, including err_cnt_o and the timer.
  - Reset mid-transaction drops any slave strobe immediately; no ack is issued.
- States: IDLE, FWD, MISS, RESP.
- IDLE:
  - On wbs_cyc_i & wbs_stb_i, decode wbs_adr_i. Overlapping windows resolve to the lowest index.
  - On the same edge, latch adr, we, sel and dat_i into the s_* registers.
  - Hit: load slave index, clear timer, go to FWD. No hit: go to MISS.
- FWD:
  - s_cyc_o[idx] and s_stb_o[idx] are high; the timer increments every cycle.
  - s_ack_i[idx] high: capture s_dat_i[idx] into wbs_dat_o, drop the strobes on the next edge, go to RESP.
  - Acks from non-selected slaves are ignored.
  - Timer reaches TIMEOUT-1 without an ack: wbs_dat_o <= ERR_DATA, err_cnt_o increments, go to RESP.
  - Ack and timeout in the same cycle: the ack wins and no error is counted.
  - wbs_cyc_i low (master abort): drop strobes, go to IDLE, no ack, no count.
- MISS: wbs_dat_o <= ERR_DATA, err_cnt_o increments, go to RESP. No slave is strobed.
- RESP: wbs_ack_o high for exactly one cycle, then IDLE.
- Writes: wbs_dat_o is still updated from the slave or ERR_DATA; the master ignores it.
- Latency: a zero-wait slave (combinational ack) gives wbs_ack_o 2 cycles after the master's first stb cycle. Each slave wait state adds 1 cycle.
- Back-to-back: stb still asserted in IDLE after RESP is treated as a new transaction.
- err_cnt_o saturates at 255 and does not wrap.
- Only one outstanding transaction; no pipelined Wishbone.

Test Plan:
- Read 0x3000_0010, slave0 acks immediately with 0x1234_5678 -> only s_stb_o[0] asserted; wbs_ack_o high one cycle, 2 cycles after stb; wbs_dat_o=0x1234_5678.
- Write 0x3800_0004 data 0xA5A5_0001 sel 4'b0011, slave1 with 3 wait states -> s_adr_o/s_dat_o/s_sel_o match the request; ack 5 cycles after stb; err_cnt_o=0.
- Read 0x2000_0000 (unmapped) -> no s_stb_o; ack at cycle 2; wbs_dat_o=0xDEAD_BEEF; err_cnt_o=1.
- Read slave0 which never acks, TIMEOUT=8 -> strobe held 8 cycles then dropped; ack with 0xDEAD_BEEF; err_cnt_o increments.
- Master drops cyc in the 2nd FWD cycle -> strobes low next edge; no wbs_ack_o; err_cnt_o unchanged. Pulse wbs_rst_ni low mid-FWD -> all outputs 0 asynchronously.
- Non-selected s_ack_i[1] pulses during a slave0 transaction -> ignored. Drive 300 misses -> err_cnt_o saturates at 255.
